hazard_forward_ctrl: RTL and testbench

//  Sequences the operand-forwarding 3:1 muxes and the PC/IF-ID write enables of the 5-stage pipeline.

---
 rtl/hazard_pkg.sv | 22 ++
 rtl/hazard_src_match.sv | 36 +++
 rtl/hazard_forward_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_hazard_forward_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard/forwarding controller: mux selects, FSM states and the
// per-stage shadow control record.
package hazard_pkg;

  // Must stay in step with the mux_3x1 input ordering in EX.
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic {
    StRun   = 1'b0,
    StStall = 1'b1
  } state_e;

  // rd is kept beside this record since its width follows the REG_AW parameter.
  typedef struct packed {
    logic valid;
    logic reg_write;
    logic mem_read;
  } stage_ctl_t;

endpackage

// File: rtl/hazard_src_match.sv
// Compares one ID source register against the EX and MEM shadow producers and
// returns the forwarding select plus load-use / any-hit flags.
module hazard_src_match
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs,
  input  stage_ctl_t        ex_ctl,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              mem_valid,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] mem_rd,
  output logic [1:0]        sel,
  output logic              load_hit,
  output logic              any_hit
);

  logic ex_hit;
  logic mem_hit;

  always_comb begin
    ex_hit  = (rs != '0) && ex_ctl.valid && ex_ctl.reg_write && (ex_rd == rs);
    mem_hit = (rs != '0) && mem_valid && mem_reg_write && (mem_rd == rs);
    // Youngest producer wins.
    sel = FWD_RF;
    if (ex_hit) begin
      sel = FWD_MEM;
    end else if (mem_hit) begin
      sel = FWD_WB;
    end
    load_hit = ex_hit && ex_ctl.mem_read;
    any_hit  = ex_hit || mem_hit;
  end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Pipeline hazard controller: shadows EX/MEM producer info, registers EX forwarding selects,
// and drives stall/flush enables plus stall/flush performance counters.
module hazard_forward_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW     = 5,
  parameter bit          ENABLE_FWD = 1'b1,
  parameter int unsigned CNT_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              ex_branch_taken,
  input  logic              mem_stall,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  stage_ctl_t        ex_ctl_q, ex_ctl_d;
  logic [REG_AW-1:0] ex_rd_q, ex_rd_d;
  logic              mem_valid_q, mem_valid_d;
  logic              mem_rw_q, mem_rw_d;
  logic [REG_AW-1:0] mem_rd_q, mem_rd_d;
  logic [1:0]        sel_a_q, sel_a_d, sel_b_q, sel_b_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  state_e            state_q, state_d;

  logic [1:0] a_sel, b_sel;
  logic       a_load, b_load, a_any, b_any;
  logic       hazard_stall;
  logic       flush;

  hazard_src_match #(.REG_AW(REG_AW)) u_match_rs1 (
    .rs            (id_rs1),
    .ex_ctl        (ex_ctl_q),
    .ex_rd         (ex_rd_q),
    .mem_valid     (mem_valid_q),
    .mem_reg_write (mem_rw_q),
    .mem_rd        (mem_rd_q),
    .sel           (a_sel),
    .load_hit      (a_load),
    .any_hit       (a_any)
  );

  hazard_src_match #(.REG_AW(REG_AW)) u_match_rs2 (
    .rs            (id_rs2),
    .ex_ctl        (ex_ctl_q),
    .ex_rd         (ex_rd_q),
    .mem_valid     (mem_valid_q),
    .mem_reg_write (mem_rw_q),
    .mem_rd        (mem_rd_q),
    .sel           (b_sel),
    .load_hit      (b_load),
    .any_hit       (b_any)
  );

  always_comb begin
    flush = ex_branch_taken;
    if (ENABLE_FWD) begin
      hazard_stall = id_valid && (a_load || b_load);
    end else begin
      hazard_stall = id_valid && (a_any || b_any);
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; a frozen pipeline holds whatever state it was in.
  always_comb begin
    state_d = state_q;
    if (!mem_stall) begin
      unique case (state_q)
        StRun:   state_d = (hazard_stall && !flush) ? StStall : StRun;
        StStall: state_d = (flush || !hazard_stall) ? StRun : StStall;
        default: state_d = StRun;
      endcase
    end
  end

  // FSM outputs, priority mem_stall > flush > hazard_stall > normal.
  always_comb begin
    pc_write    = 1'b0;
    if_id_write = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    if (!rst_n || mem_stall) begin
      pc_write    = 1'b0;
    end else if (flush) begin
      pc_write    = 1'b1;
      if_id_write = 1'b1;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (hazard_stall) begin
      id_ex_flush = 1'b1;
    end else begin
      pc_write    = 1'b1;
      if_id_write = 1'b1;
    end
  end

  // Shadow stages, selects and counters.
  always_comb begin
    ex_ctl_d    = ex_ctl_q;
    ex_rd_d     = ex_rd_q;
    mem_valid_d = mem_valid_q;
    mem_rw_d    = mem_rw_q;
    mem_rd_d    = mem_rd_q;
    sel_a_d     = sel_a_q;
    sel_b_d     = sel_b_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!mem_stall) begin
      mem_valid_d = ex_ctl_q.valid;
      mem_rw_d    = ex_ctl_q.reg_write;
      mem_rd_d    = ex_rd_q;
      if (flush || hazard_stall) begin
        ex_ctl_d = '0;
        sel_a_d  = FWD_RF;
        sel_b_d  = FWD_RF;
        if (flush) begin
          flush_cnt_d = flush_cnt_q + CntOne;
        end else begin
          stall_cnt_d = stall_cnt_q + CntOne;
        end
      end else begin
        ex_ctl_d = '{valid: id_valid, reg_write: id_reg_write, mem_read: id_mem_read};
        ex_rd_d  = id_rd;
        sel_a_d  = ENABLE_FWD ? a_sel : FWD_RF;
        sel_b_d  = ENABLE_FWD ? b_sel : FWD_RF;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_ctl_q    <= '0;
      ex_rd_q     <= '0;
      mem_valid_q <= 1'b0;
      mem_rw_q    <= 1'b0;
      mem_rd_q    <= '0;
      sel_a_q     <= FWD_RF;
      sel_b_q     <= FWD_RF;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_ctl_q    <= ex_ctl_d;
      ex_rd_q     <= ex_rd_d;
      mem_valid_q <= mem_valid_d;
      mem_rw_q    <= mem_rw_d;
      mem_rd_q    <= mem_rd_d;
      sel_a_q     <= sel_a_d;
      sel_b_q     <= sel_b_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign fwd_a_sel = sel_a_q;
  assign fwd_b_sel = sel_b_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Bench for hazard_forward_ctrl: directed pipeline scenarios then random traffic, checked
// against an in-flight instruction list model.
module tb_hazard_forward_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_reg_write, id_mem_read, ex_branch_taken, mem_stall;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic        pc_write, if_id_write, if_id_flush, id_ex_flush;
  logic [31:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_forward_ctrl #(.REG_AW(5), .ENABLE_FWD(1'b1), .CNT_W(32)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_valid        (id_valid),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_rd           (id_rd),
    .id_reg_write    (id_reg_write),
    .id_mem_read     (id_mem_read),
    .ex_branch_taken (ex_branch_taken),
    .mem_stall       (mem_stall),
    .fwd_a_sel       (fwd_a_sel),
    .fwd_b_sel       (fwd_b_sel),
    .pc_write        (pc_write),
    .if_id_write     (if_id_write),
    .if_id_flush     (if_id_flush),
    .id_ex_flush     (id_ex_flush),
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt)
  );

  // Model: instructions currently in EX (index 0) and MEM (index 1).
  typedef struct {
    bit          v;
    int unsigned rd;
    bit          rw;
    bit          ld;
  } ins_t;

  ins_t        pipe[2];
  logic [1:0]  m_a, m_b;
  int unsigned m_stall, m_flush;
  int unsigned snap;

  function automatic logic [1:0] want_sel(input int unsigned rs);
    for (int k = 0; k < 2; k++) begin
      if (rs != 0 && pipe[k].v && pipe[k].rw && pipe[k].rd == rs) return (k == 0) ? 2'd2 : 2'd1;
    end
    return 2'd0;
  endfunction

  function automatic bit load_use();
    int unsigned r1, r2;
    r1 = id_rs1;
    r2 = id_rs2;
    return id_valid && pipe[0].v && pipe[0].rw && pipe[0].ld &&
           ((r1 != 0 && pipe[0].rd == r1) || (r2 != 0 && pipe[0].rd == r2));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit v, input int unsigned rs1, input int unsigned rs2,
                       input int unsigned rd, input bit rw, input bit ld, input bit br,
                       input bit ms);
    id_valid        = v;
    id_rs1          = 5'(rs1);
    id_rs2          = 5'(rs2);
    id_rd           = 5'(rd);
    id_reg_write    = rw;
    id_mem_read     = ld;
    ex_branch_taken = br;
    mem_stall       = ms;
  endtask

  task automatic model_clear();
    pipe[0] = '{0, 0, 0, 0};
    pipe[1] = '{0, 0, 0, 0};
    m_a = 2'd0;
    m_b = 2'd0;
    m_stall = 0;
    m_flush = 0;
  endtask

  // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
  task automatic cycle(input string tag);
    bit hz, br, ms;
    logic [3:0] exp_en;
    logic [1:0] na, nb;
    hz = load_use();
    br = ex_branch_taken;
    ms = mem_stall;
    if (ms) exp_en = 4'b0000;
    else if (br) exp_en = 4'b1111;
    else if (hz) exp_en = 4'b0001;
    else exp_en = 4'b1100;
    #3;
    chk({tag, ".enables"}, {28'd0, pc_write, if_id_write, if_id_flush, id_ex_flush},
        {28'd0, exp_en});
    if (!ms) begin
      na = want_sel(id_rs1);
      nb = want_sel(id_rs2);
      pipe[1] = pipe[0];
      if (br || hz) begin
        pipe[0] = '{0, 0, 0, 0};
        m_a = 2'd0;
        m_b = 2'd0;
        if (br) m_flush++;
        else m_stall++;
      end else begin
        pipe[0] = '{id_valid, id_rd, id_reg_write, id_mem_read};
        m_a = na;
        m_b = nb;
      end
    end
    @(posedge clk);
    #1;
    chk({tag, ".sel_a"}, {30'd0, fwd_a_sel}, {30'd0, m_a});
    chk({tag, ".sel_b"}, {30'd0, fwd_b_sel}, {30'd0, m_b});
    chk({tag, ".stall_cnt"}, stall_cnt, m_stall);
    chk({tag, ".flush_cnt"}, flush_cnt, m_flush);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #3;
    chk({tag, ".rst_enables"}, {28'd0, pc_write, if_id_write, if_id_flush, id_ex_flush}, 32'd0);
    @(posedge clk);
    #1;
    model_clear();
    chk({tag, ".rst_sels"}, {28'd0, fwd_a_sel, fwd_b_sel}, 32'd0);
    chk({tag, ".rst_stall_cnt"}, stall_cnt, 32'd0);
    chk({tag, ".rst_flush_cnt"}, flush_cnt, 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    model_clear();
    @(posedge clk);
    #1;
    do_reset("reset");

    // 1: add x5 then consumer on rs1 -> forward from MEM
    drive(1, 1, 2, 5, 1, 0, 0, 0); cycle("t1.add");
    drive(1, 5, 0, 6, 1, 0, 0, 0); cycle("t1.use");
    chk("t1.fwd_a_mem", {30'd0, fwd_a_sel}, 32'd2);

    // 2: add x5; nop; sub rs2=x5 -> WB; then two writers of x6 -> youngest (MEM)
    drive(1, 1, 2, 5, 1, 0, 0, 0); cycle("t2.add");
    drive(0, 0, 0, 0, 0, 0, 0, 0); cycle("t2.nop");
    drive(1, 3, 5, 8, 1, 0, 0, 0); cycle("t2.sub");
    chk("t2.fwd_b_wb", {30'd0, fwd_b_sel}, 32'd1);
    drive(1, 1, 2, 6, 1, 0, 0, 0); cycle("t2.add6a");
    drive(1, 1, 2, 6, 1, 0, 0, 0); cycle("t2.add6b");
    drive(1, 6, 6, 9, 1, 0, 0, 0); cycle("t2.use6");
    chk("t2.youngest", {28'd0, fwd_a_sel, fwd_b_sel}, 32'hA);

    // 3: lw x7; add rs1=x7 -> one stall, then forward from WB
    snap = m_stall;
    drive(1, 1, 2, 7, 1, 1, 0, 0); cycle("t3.lw");
    drive(1, 7, 0, 10, 1, 0, 0, 0); cycle("t3.stall");
    chk("t3.stall_inc", stall_cnt, snap + 1);
    cycle("t3.add");
    chk("t3.fwd_a_wb", {30'd0, fwd_a_sel}, 32'd1);

    // 4: load-use coinciding with taken branch -> flush only
    snap = m_stall;
    drive(1, 1, 2, 7, 1, 1, 0, 0); cycle("t4.lw");
    drive(1, 7, 0, 10, 1, 0, 1, 0); cycle("t4.flush");
    chk("t4.stall_same", stall_cnt, snap);
    chk("t4.flush_one", flush_cnt, 32'd1);

    // 5: mem_stall for 3 cycles during load-use, then stall completes
    drive(1, 1, 2, 7, 1, 1, 0, 0); cycle("t5.lw");
    snap = m_stall;
    for (int i = 0; i < 3; i++) begin
      drive(1, 7, 0, 10, 1, 0, 0, 1); cycle("t5.frozen");
    end
    chk("t5.frozen_cnt", stall_cnt, snap);
    drive(1, 7, 0, 10, 1, 0, 0, 0); cycle("t5.stall");
    cycle("t5.add");
    chk("t5.fwd_a_wb", {30'd0, fwd_a_sel}, 32'd1);

    // 6: x0 producer/consumer never forwarded; reset during a stall
    drive(1, 1, 2, 0, 1, 1, 0, 0); cycle("t6.ldx0");
    drive(1, 0, 0, 3, 1, 0, 0, 0); cycle("t6.usex0");
    chk("t6.x0_sel", {28'd0, fwd_a_sel, fwd_b_sel}, 32'd0);
    drive(1, 1, 2, 7, 1, 1, 0, 0); cycle("t6.lw");
    drive(1, 7, 0, 10, 1, 0, 0, 0);
    do_reset("t6.midstall");
    cycle("t6.after_rst");
    chk("t6.no_stall", {31'd0, pc_write}, 32'd1);

    // Random traffic over a small register set to provoke frequent hazards
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 99) < 85, $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 7), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 15);
      cycle("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
